// File: rtl/ss_pkg.sv
// rtl/ss_pkg.sv - shared constants and types for the seven-segment scanner
//
// Purpose: digit count, blank patterns, segment type and slot phase enum
//          used by ss_refresh_timer and ss_scanner.
// Ports:   none (package).
package ss_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [6:0] seg_t;

  localparam seg_t       SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Phase within one digit slot; decoded from the slot counter, not stored.
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/ss_refresh_timer.sv
// rtl/ss_refresh_timer.sv - slot counter and digit index for the display scan
//
// Purpose: counts DIGIT_CYCLES clocks per digit slot and steps the digit
//          index 0..3 at the end of each slot.
// Ports:   i_clk         clock
//          i_rst         synchronous active-low reset
//          o_idx         digit currently being scanned
//          o_in_blank    slot counter is inside the blanking gap
//          o_frame_tick  counter state is cnt=0, idx=0 (first cycle of a frame)
module ss_refresh_timer
  import ss_pkg::*;
#(
  parameter int DIGIT_CYCLES = 25000,
  parameter int BLANK_CYCLES = 250
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic [1:0] o_idx,
  output logic       o_in_blank,
  output logic       o_frame_tick
);

  localparam int            CW      = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] C_LAST  = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] C_BLANK = CW'(BLANK_CYCLES);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (r_cnt == C_LAST) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;  // natural 2-bit wrap gives 3 -> 0
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_idx        = r_idx;
  assign o_in_blank   = (r_cnt < C_BLANK);
  assign o_frame_tick = (r_cnt == '0) && (r_idx == 2'd0);

endmodule

// File: rtl/ss_scanner.sv
// rtl/ss_scanner.sv - four-digit common-anode seven-segment scan driver
//
// Purpose: snapshots four active-low segment patterns once per frame and
//          scans them onto a shared cathode bus with a blanking gap at the
//          start of every digit slot.
// Ports:   i_clk            clock
//          i_rst            synchronous active-low reset
//          i_seg3..i_seg0   active-low segment patterns (seg3 leftmost)
//          i_dp_mask        per-digit decimal point enable, active-high
//          i_digit_en       per-digit enable, active-high
//          o_seg_out        active-low cathode bus
//          o_dp_out         active-low decimal point cathode
//          o_an_out         active-low anode selects, bit i = digit i
//          o_frame_start    one-cycle pulse when a new snapshot is valid
module ss_scanner
  import ss_pkg::*;
#(
  parameter int DIGIT_CYCLES = 25000,
  parameter int BLANK_CYCLES = 250
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_seg3,
  input  logic [6:0] i_seg2,
  input  logic [6:0] i_seg1,
  input  logic [6:0] i_seg0,
  input  logic [3:0] i_dp_mask,
  input  logic [3:0] i_digit_en,
  output logic [6:0] o_seg_out,
  output logic       o_dp_out,
  output logic [3:0] o_an_out,
  output logic       o_frame_start
);

  logic [1:0]  w_idx;
  logic        w_in_blank;
  logic        w_frame_tick;
  slot_state_t w_state;

  ss_refresh_timer #(
    .DIGIT_CYCLES (DIGIT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .o_idx        (w_idx),
    .o_in_blank   (w_in_blank),
    .o_frame_tick (w_frame_tick)
  );

  assign w_state = w_in_blank ? ST_BLANK : ST_SHOW;

  seg_t       r_shadow_seg [NUM_DIGITS];
  logic [3:0] r_shadow_dp;
  logic [3:0] r_shadow_en;

  seg_t       r_seg_out;
  logic       r_dp_out;
  logic [3:0] r_an_out;
  logic       r_frame_start;

  // The frame's first cycle is always blank, so the shadow registers can
  // reload there without the outputs ever mixing old and new values.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_shadow_seg[i] <= SEG_BLANK;
      end
      r_shadow_dp   <= '0;
      r_shadow_en   <= '0;
      r_seg_out     <= SEG_BLANK;
      r_dp_out      <= 1'b1;
      r_an_out      <= AN_OFF;
      r_frame_start <= 1'b0;
    end else begin
      if (w_frame_tick) begin
        r_shadow_seg[0] <= i_seg0;
        r_shadow_seg[1] <= i_seg1;
        r_shadow_seg[2] <= i_seg2;
        r_shadow_seg[3] <= i_seg3;
        r_shadow_dp     <= i_dp_mask;
        r_shadow_en     <= i_digit_en;
      end
      r_frame_start <= w_frame_tick;
      if (w_state == ST_SHOW && r_shadow_en[w_idx]) begin
        r_an_out  <= AN_OFF & ~(4'(1) << w_idx);
        r_seg_out <= r_shadow_seg[w_idx];
        r_dp_out  <= ~r_shadow_dp[w_idx];
      end else begin
        r_an_out  <= AN_OFF;
        r_seg_out <= SEG_BLANK;
        r_dp_out  <= 1'b1;
      end
    end
  end

  assign o_seg_out     = r_seg_out;
  assign o_dp_out      = r_dp_out;
  assign o_an_out      = r_an_out;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_ss_scanner.sv
// tb/tb_ss_scanner.sv - directed and random-input bench for ss_scanner
module tb_ss_scanner;

  logic       clk;
  logic       rst;
  logic [6:0] seg3, seg2, seg1, seg0;
  logic [3:0] dp_mask, digit_en;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [3:0] an_out;
  logic       frame_start;

  int n_total;
  int n_bad;

  ss_scanner #(
    .DIGIT_CYCLES (8),
    .BLANK_CYCLES (2)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_seg3        (seg3),
    .i_seg2        (seg2),
    .i_seg1        (seg1),
    .i_seg0        (seg0),
    .i_dp_mask     (dp_mask),
    .i_digit_en    (digit_en),
    .o_seg_out     (seg_out),
    .o_dp_out      (dp_out),
    .o_an_out      (an_out),
    .o_frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock edge; outputs are then sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected outputs after edge Ek, given the snapshot in force for that frame.
  // segs packs {seg3, seg2, seg1, seg0}.
  task automatic check_edge(input int k, input logic [3:0] en, input logic [3:0] dp,
                            input logic [27:0] segs);
    int         cnt;
    int         idx;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    cnt = k % 8;
    idx = (k / 8) % 4;
    if (cnt < 2 || !en[idx]) begin
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end else begin
      e_an  = 4'hF & ~(4'b0001 << idx);
      e_seg = segs[idx*7 +: 7];
      e_dp  = ~dp[idx];
    end
    chk($sformatf("an_E%0d", k), 32'(an_out), 32'(e_an));
    chk($sformatf("seg_E%0d", k), 32'(seg_out), 32'(e_seg));
    chk($sformatf("dp_E%0d", k), 32'(dp_out), 32'(e_dp));
    chk($sformatf("fs_E%0d", k), 32'(frame_start), 32'((k % 32) == 0));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_an"}, 32'(an_out), 32'h0F);
    chk({tag, "_seg"}, 32'(seg_out), 32'h7F);
    chk({tag, "_dp"}, 32'(dp_out), 32'h1);
    chk({tag, "_fs"}, 32'(frame_start), 32'h0);
  endtask

  initial begin
    logic [27:0] f0, f1;
    int          last_fs;
    int          n_fs;
    n_total  = 0;
    n_bad    = 0;
    rst      = 1'b0;
    seg0     = 7'h40;
    seg1     = 7'h79;
    seg2     = 7'h24;
    seg3     = 7'h30;
    digit_en = 4'hF;
    dp_mask  = 4'h0;

    // Reset state
    repeat (3) tick();
    check_reset_state("rst");

    // Reset release, snapshot, seg0 change mid-frame
    f0  = {7'h30, 7'h24, 7'h79, 7'h40};
    f1  = {7'h30, 7'h24, 7'h79, 7'h12};
    rst = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      tick();
      check_edge(k, 4'hF, 4'h0, f0);
    end
    seg0 = 7'h12;
    for (int k = 5; k <= 63; k++) begin
      tick();
      check_edge(k, 4'hF, 4'h0, (k < 32) ? f0 : f1);
    end

    // Partial digit enables with one decimal point
    rst = 1'b0;
    tick();
    check_reset_state("rst2");
    digit_en = 4'b0101;
    dp_mask  = 4'b0100;
    rst      = 1'b1;
    for (int k = 0; k <= 31; k++) begin
      tick();
      check_edge(k, 4'b0101, 4'b0100, f1);
    end

    // Mid-slot reset at E13, then the following edge acts as E0
    rst      = 1'b0;
    tick();
    digit_en = 4'hF;
    dp_mask  = 4'h0;
    rst      = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      tick();
      check_edge(k, 4'hF, 4'h0, f1);
    end
    rst = 1'b0;
    tick();
    check_reset_state("rst_E13");
    rst = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      tick();
      check_edge(k, 4'hF, 4'h0, f1);
    end

    // Three frames with inputs changing every cycle
    rst = 1'b0;
    tick();
    rst     = 1'b1;
    last_fs = -1;
    n_fs    = 0;
    for (int k = 0; k < 96; k++) begin
      seg0     = 7'($urandom);
      seg1     = 7'($urandom);
      seg2     = 7'($urandom);
      seg3     = 7'($urandom);
      dp_mask  = 4'($urandom);
      digit_en = 4'($urandom);
      tick();
      chk($sformatf("onehot_E%0d", k), 32'($countones(~an_out) <= 1), 32'h1);
      if ((k % 8) < 2) chk($sformatf("gap_E%0d", k), 32'(an_out), 32'h0F);
      if (frame_start) begin
        if (last_fs >= 0) chk($sformatf("fs_space_E%0d", k), 32'(k - last_fs), 32'd32);
        last_fs = k;
        n_fs++;
      end
    end
    chk("fs_count", 32'(n_fs), 32'd3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
